// File: rtl/dsm_pdm_out_pkg.sv
// Shared constants for the interpolator/PDM output chain: sample and accumulator widths,
// buffer sizing, modulator feedback levels, request FSM encodings and saturation helpers.
package dsm_pdm_out_pkg;

    localparam int SAMPLE_W   = 16;
    localparam int BURST      = 32;
    localparam int FIFO_DEPTH = 64;
    localparam int LOW_WM     = 32;
    localparam int TICK_DIV   = 16;
    localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1;

    localparam int A1_W  = 20;
    localparam int A2_W  = 24;
    localparam int FB_W  = 17;
    localparam int SUM_W = 26;

    localparam logic signed [FB_W-1:0] FB_POS = 17'sd32767;
    localparam logic signed [FB_W-1:0] FB_NEG = -17'sd32768;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Clamp when the bits above the target sign bit disagree with it.
    function automatic logic signed [A1_W-1:0] sat_a1(input logic signed [SUM_W-1:0] v);
        if ((&v[SUM_W-1:A1_W-1]) || !(|v[SUM_W-1:A1_W-1]))
            return v[A1_W-1:0];
        else if (v[SUM_W-1])
            return {1'b1, {(A1_W-1){1'b0}}};
        else
            return {1'b0, {(A1_W-1){1'b1}}};
    endfunction

    function automatic logic signed [A2_W-1:0] sat_a2(input logic signed [SUM_W-1:0] v);
        if ((&v[SUM_W-1:A2_W-1]) || !(|v[SUM_W-1:A2_W-1]))
            return v[A2_W-1:0];
        else if (v[SUM_W-1])
            return {1'b1, {(A2_W-1){1'b0}}};
        else
            return {1'b0, {(A2_W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/dsm_pdm_out_if.sv
// Link between the interpolator side and the PDM output stage, plus status outputs.
interface dsm_pdm_out_if;
    import dsm_pdm_out_pkg::*;

    // din is captured on every cycle din_valid is high; there is no ready, so a sample
    // arriving while the buffer is full is dropped and flagged. sample_req is a
    // single-cycle pulse asking upstream for exactly one input sample (BURST outputs).
    logic signed [SAMPLE_W-1:0] din;
    logic                       din_valid;
    logic                       sample_req;
    logic                       pdm_out;
    logic [LEVEL_W-1:0]         fifo_level;
    logic                       underflow;
    logic                       overflow;
    logic [1:0]                 req_state;

    modport master (
        output din, din_valid,
        input  sample_req, pdm_out, fifo_level, underflow, overflow, req_state
    );

    modport slave (
        input  din, din_valid,
        output sample_req, pdm_out, fifo_level, underflow, overflow, req_state
    );

endinterface

// File: rtl/dsm_pdm_out_sync_fifo.sv
// Single-clock FIFO with one write and one read port, combinational read data and a
// registered occupancy count. The caller never pushes when full without popping.
module dsm_pdm_out_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 64
) (
    input  logic                     ACLK,
    input  logic                     ARST,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge ACLK) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/dsm_pdm_out.sv
// PDM output stage: buffers interpolator bursts, drains one sample per output tick into
// a 2nd-order delta-sigma modulator, and paces upstream with single-cycle requests.
module dsm_pdm_out
    import dsm_pdm_out_pkg::*;
(
    input  logic          ACLK,
    input  logic          ARST,
    dsm_pdm_out_if.slave  bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int OUT_W  = $clog2(BURST) + 1;

    logic [TICK_W-1:0]          tick_cnt;
    logic                       tick;
    logic                       push;
    logic                       pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [SAMPLE_W-1:0]        fifo_rdata;
    logic [LEVEL_W-1:0]         level;

    logic signed [SAMPLE_W-1:0] x;
    logic                       mod_en;
    logic                       underflow_q;
    logic                       overflow_q;

    logic [1:0]                 state;
    logic [OUT_W-1:0]           outstanding;

    logic signed [FB_W-1:0]     fb;
    logic signed [SUM_W-1:0]    a1_sum;
    logic signed [SUM_W-1:0]    a2_sum;
    logic signed [A1_W-1:0]     a1;
    logic signed [A1_W-1:0]     a1_new;
    logic signed [A2_W-1:0]     a2;
    logic signed [A2_W-1:0]     a2_new;
    logic                       pdm_q;

    assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign pop  = tick && !fifo_empty;
    // A full buffer still accepts a sample when the same cycle pops one.
    assign push = bus.din_valid && (!fifo_full || pop);

    always_ff @(posedge ACLK) begin
        if (ARST)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    dsm_pdm_out_sync_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .ACLK  (ACLK),
        .ARST  (ARST),
        .push  (push),
        .wdata (bus.din),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            x           <= '0;
            mod_en      <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            mod_en <= tick;
            if (pop)
                x <= $signed(fifo_rdata);
            if (tick && fifo_empty)
                underflow_q <= 1'b1;
            if (bus.din_valid && fifo_full && !pop)
                overflow_q <= 1'b1;
        end
    end

    // Every din_valid counts against the outstanding burst, including dropped samples.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state       <= ST_IDLE;
            outstanding <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (level <= LEVEL_W'(LOW_WM))
                        state <= ST_REQ;
                end
                ST_REQ: begin
                    outstanding <= OUT_W'(BURST);
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.din_valid) begin
                        outstanding <= outstanding - 1'b1;
                        if (outstanding == OUT_W'(1))
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        fb     = pdm_q ? FB_POS : FB_NEG;
        a1_sum = SUM_W'(a1) + SUM_W'(x) - SUM_W'(fb);
        a1_new = sat_a1(a1_sum);
        a2_sum = SUM_W'(a2) + SUM_W'(a1_new) - SUM_W'(fb);
        a2_new = sat_a2(a2_sum);
    end

    // Runs one cycle after each tick so it always sees the freshly popped (or held) x.
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            a1    <= '0;
            a2    <= '0;
            pdm_q <= 1'b0;
        end else if (mod_en) begin
            a1    <= a1_new;
            a2    <= a2_new;
            pdm_q <= !a2_new[A2_W-1];
        end
    end

    assign bus.sample_req = (state == ST_REQ);
    assign bus.pdm_out    = pdm_q;
    assign bus.fifo_level = level;
    assign bus.underflow  = underflow_q;
    assign bus.overflow   = overflow_q;
    assign bus.req_state  = state;

endmodule
